// File: rtl/lab3_pio_arb_pkg.sv
// Shared definitions for the PIO write arbiter.
//   pio_state_e   : arbiter FSM encoding (READ only entered when the
//                   LAB3_PIO_ARBITER_VERIFY_EN readback build is selected)
//   PIO_ADDR_DATA : Avalon address of the PIO data register
//   MAX_REQ       : largest supported requester count (grant ids are 3 bits)
package lab3_pio_arb_pkg;

  localparam int         MAX_REQ       = 8;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } pio_state_e;

endpackage

// File: rtl/lab3_rr_select.sv
// Round-robin requester selector, purely combinational.
//   req        : pending requests, one bit per requester
//   last_grant : requester served most recently
//   valid      : at least one request pending
//   index      : first set req searching from (last_grant+1) mod NUM_REQ
module lab3_rr_select
  import lab3_pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_grant,
  output logic               valid,
  output logic [2:0]         index
);

  // Padded to MAX_REQ so the 3-bit candidate can index it for any NUM_REQ.
  logic [MAX_REQ-1:0] req_ext;
  logic [3:0]         cand;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    valid                  = 1'b0;
    index                  = last_grant;
    cand                   = '0;
    // last_grant < NUM_REQ and off <= NUM_REQ, so one subtraction is a full mod.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_grant} + 4'(off);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!valid && req_ext[cand[2:0]]) begin
        valid = 1'b1;
        index = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/lab3_pio_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one Avalon PIO.
// Each grant performs one write cycle, optionally a readback cycle, then a
// one-cycle ack to the granted requester.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req, req_data       : per-requester request and DATA_W-bit value
//   ack, busy, grant_id : completion pulse, FSM-not-idle, served requester
//   pio_*               : Avalon master port to the PIO slave
//   err                 : sticky readback mismatch
// Build option: define LAB3_PIO_ARBITER_VERIFY_EN to add the READ state,
// which checks pio_readdata against the written value and sets err.
module lab3_pio_arbiter
  import lab3_pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [31:0]               pio_writedata,
  input  logic [31:0]               pio_readdata,
  output logic                      err
);

  pio_state_e  state_q;
  logic [2:0]  last_grant_q;
  logic [2:0]  grant_id_q;
  logic [DATA_W-1:0] data_q;
  logic        sel_valid;
  logic [2:0]  sel_idx;
  logic [MAX_REQ-1:0][DATA_W-1:0] req_pad;

  // Read data bits not compared are intentionally ignored.
  logic unused_rd;
  assign unused_rd = ^pio_readdata;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req_data;
  end

  lab3_rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (sel_valid),
    .index      (sel_idx)
  );

`ifdef LAB3_PIO_ARBITER_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (state_q == ST_READ && pio_readdata[DATA_W-1:0] != data_q)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      grant_id_q   <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (sel_valid) begin
          state_q    <= ST_WRITE;
          grant_id_q <= sel_idx;
          data_q     <= req_pad[sel_idx];  // snapshot: later req_data edits ignored
        end
`ifdef LAB3_PIO_ARBITER_VERIFY_EN
        ST_WRITE: state_q <= ST_READ;
        ST_READ:  state_q <= ST_DONE;
`else
        ST_WRITE: state_q <= ST_DONE;
`endif
        ST_DONE: begin
          last_grant_q <= grant_id_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus and ack decode straight from state so reset clears them at once.
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    if (state_q == ST_WRITE) begin
      pio_chipselect = 1'b1;
      pio_write_n    = 1'b0;
      pio_writedata  = 32'(data_q);
    end
`ifdef LAB3_PIO_ARBITER_VERIFY_EN
    if (state_q == ST_READ) pio_chipselect = 1'b1;
`endif
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state_q == ST_DONE) && (grant_id_q == 3'(i));
  end

  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = grant_id_q;
  assign pio_address = PIO_ADDR_DATA;

endmodule

// File: tb/tb_lab3_pio_arbiter.sv
// Directed self-checking bench for lab3_pio_arbiter (NUM_REQ=4, DATA_W=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_lab3_pio_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  grant_id;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  // PIO register model; corrupt forces a bad readback.
  logic [31:0] pio_reg = '0;
  logic        corrupt;

  lab3_pio_arbiter #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .busy           (busy),
    .grant_id       (grant_id),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata;
  assign pio_readdata = corrupt ? 32'h0 : pio_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge before the grant edge with req already set.
  // Returns on the falling edge of the DONE cycle.
  task automatic do_txn(input logic [2:0] id, input logic [3:0] d,
                        input bit drop, input bit exp_err);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    @(negedge clk);
    check("wr_cs",    32'(pio_chipselect), 32'd1);
    check("wr_wn",    32'(pio_write_n),    32'd0);
    check("wr_data",  pio_writedata,       32'(d));
    check("wr_gid",   32'(grant_id),       32'(id));
    check("wr_busy",  32'(busy),           32'd1);
    check("wr_ack",   32'(ack),            32'd0);
    if (drop) begin
      req      = '0;
      req_data = ~req_data;
    end
`ifdef LAB3_PIO_ARBITER_VERIFY_EN
    @(negedge clk);
    check("rd_cs",    32'(pio_chipselect), 32'd1);
    check("rd_wn",    32'(pio_write_n),    32'd1);
    check("rd_data",  pio_writedata,       32'd0);
    check("rd_ack",   32'(ack),            32'd0);
`endif
    @(negedge clk);
    check("done_ack", 32'(ack),            32'(oh));
    check("done_cs",  32'(pio_chipselect), 32'd0);
    check("done_wn",  32'(pio_write_n),    32'd1);
    check("done_err", 32'(err),            32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    corrupt  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy),           32'd0);
    check("rst_ack",  32'(ack),            32'd0);
    check("rst_gid",  32'(grant_id),       32'd0);
    check("rst_cs",   32'(pio_chipselect), 32'd0);
    check("rst_wn",   32'(pio_write_n),    32'd1);
    check("rst_wd",   pio_writedata,       32'd0);
    check("rst_err",  32'(err),            32'd0);
    check("rst_addr", 32'(pio_address),    32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 0.
    req = 4'b0001; req_data = 16'h000A;
    do_txn(3'd0, 4'hA, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);
    check("single_after_ack",  32'(ack),  32'd0);
    check("single_after_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("single_no_regrant", 32'(busy), 32'd0);

    // Fresh reset so requester 0 is first, then all four held.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1111; req_data = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      do_txn(3'(k % 4), 4'((k % 4) + 1), 1'b0, 1'b0);
      if (k == 4) req = 4'b0001;
      @(negedge clk);
      check("rr_gap_busy", 32'(busy), 32'd0);
    end

    // Fairness: req0 held, req2 raised at the end of a req0 transaction.
    do_txn(3'd0, 4'h1, 1'b0, 1'b0);
    req = 4'b0101;
    @(negedge clk);
    do_txn(3'd2, 4'h3, 1'b0, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    do_txn(3'd0, 4'h1, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // Reset in the middle of a write aborts it without an ack.
    req = 4'b0100; req_data = 16'h0700;
    @(negedge clk);
    check("abort_wr_cs", 32'(pio_chipselect), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_cs",   32'(pio_chipselect), 32'd0);
    check("abort_ack",  32'(ack),            32'd0);
    check("abort_busy", 32'(busy),           32'd0);
    check("abort_wn",   32'(pio_write_n),    32'd1);
    req = 4'b0010; req_data = 16'h0090;
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(3'd1, 4'h9, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // Requester 3 drops req and scrambles data right after its grant.
    req = 4'b1000; req_data = 16'hC000;
    do_txn(3'd3, 4'hC, 1'b1, 1'b0);
    @(negedge clk);
    check("drop_ack_once", 32'(ack),  32'd0);
    check("drop_idle",     32'(busy), 32'd0);
    @(negedge clk);
    check("drop_no_regrant", 32'(busy), 32'd0);

`ifdef LAB3_PIO_ARBITER_VERIFY_EN
    // Readback mismatch: sticky err, ack still issued.
    corrupt = 1'b1;
    req = 4'b0001; req_data = 16'h0005;
    do_txn(3'd0, 4'h5, 1'b0, 1'b1);
    req = '0; corrupt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
